// File: rtl/dds_note_sequencer.sv
// dds_note_sequencer: host-loaded step sequencer that walks a (note, duration)
// pattern RAM, driving NOTE/GATE to note2dds and timing steps with a tick prescaler.
module dds_note_sequencer #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 50000,
    parameter int ARTIC    = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WR_EN,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [7:0]       WR_NOTE,
    input  logic [DUR_W-1:0] WR_DUR,
    input  logic             START,
    input  logic             STOP,
    input  logic             LOOP,
    input  logic [AW-1:0]    LAST,
    output logic [7:0]       NOTE,
    output logic             GATE,
    output logic [AW-1:0]    STEP,
    output logic             BUSY,
    output logic             DONE
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY} state_t;

    state_t               r_state, w_state_n;
    logic [8+DUR_W-1:0]   r_mem [DEPTH];
    logic [7:0]           r_note, w_note_n;
    logic                 r_gate, w_gate_n;
    logic [AW-1:0]        r_step, w_step_n;
    logic                 r_busy, w_busy_n;
    logic                 r_done, w_done_n;
    logic [PW-1:0]        r_presc, w_presc_n;
    logic [DUR_W-1:0]     r_dcnt, w_dcnt_n;
    logic [DUR_W-1:0]     r_dorig, w_dorig_n;
    logic [AW-1:0]        r_last, w_last_n;
    logic                 r_loop, w_loop_n;

    logic [7:0]           w_ent_note;
    logic [DUR_W-1:0]     w_ent_dur;
    logic                 w_tick;

    assign w_ent_note = r_mem[r_step][8+DUR_W-1:DUR_W];
    // A stored duration of 0 plays as a single tick
    assign w_ent_dur  = (r_mem[r_step][DUR_W-1:0] == '0) ? DUR_W'(1)
                                                         : r_mem[r_step][DUR_W-1:0];
    assign w_tick     = (r_presc == TICK_LAST);

    // Host writes to the pattern RAM in any state; contents are never reset
    always_ff @(posedge CLK) begin
        if (WR_EN)
            r_mem[WR_ADDR] <= {WR_NOTE, WR_DUR};
    end

    // Next-state and datapath update; STOP overrides every state
    always_comb begin
        w_state_n = r_state;
        w_note_n  = r_note;
        w_gate_n  = r_gate;
        w_step_n  = r_step;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        w_presc_n = r_presc;
        w_dcnt_n  = r_dcnt;
        w_dorig_n = r_dorig;
        w_last_n  = r_last;
        w_loop_n  = r_loop;
        if (STOP) begin
            w_state_n = S_IDLE;
            w_gate_n  = 1'b0;
            w_busy_n  = 1'b0;
            w_presc_n = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_gate_n = 1'b0;
                    w_busy_n = 1'b0;
                    if (START) begin
                        w_state_n = S_FETCH;
                        w_step_n  = '0;
                        w_busy_n  = 1'b1;
                        w_last_n  = LAST;
                        w_loop_n  = LOOP;
                    end
                end
                S_FETCH: begin
                    w_state_n = S_PLAY;
                    w_note_n  = w_ent_note;
                    w_gate_n  = (w_ent_note != 8'd0);
                    w_dcnt_n  = w_ent_dur;
                    w_dorig_n = w_ent_dur;
                    w_presc_n = '0;
                end
                S_PLAY: begin
                    if (w_tick) begin
                        w_presc_n = '0;
                        w_dcnt_n  = r_dcnt - DUR_W'(1);
                        // Release GATE for the final tick of multi-tick steps
                        if ((ARTIC != 0) && (r_dorig > DUR_W'(1)) && (r_dcnt == DUR_W'(2)))
                            w_gate_n = 1'b0;
                        if (r_dcnt == DUR_W'(1)) begin
                            if (r_step != r_last) begin
                                w_step_n  = r_step + AW'(1);
                                w_state_n = S_FETCH;
                            end else if (r_loop) begin
                                w_step_n  = '0;
                                w_state_n = S_FETCH;
                            end else begin
                                w_state_n = S_IDLE;
                                w_gate_n  = 1'b0;
                                w_busy_n  = 1'b0;
                                w_done_n  = 1'b1;
                            end
                        end
                    end else begin
                        w_presc_n = r_presc + PW'(1);
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_note  <= '0;
            r_gate  <= 1'b0;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_presc <= '0;
            r_dcnt  <= '0;
            r_dorig <= '0;
            r_last  <= '0;
            r_loop  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_note  <= w_note_n;
            r_gate  <= w_gate_n;
            r_step  <= w_step_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_presc <= w_presc_n;
            r_dcnt  <= w_dcnt_n;
            r_dorig <= w_dorig_n;
            r_last  <= w_last_n;
            r_loop  <= w_loop_n;
        end
    end

    assign NOTE = r_note;
    assign GATE = r_gate;
    assign STEP = r_step;
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule

// File: tb/tb_dds_note_sequencer.sv
// Directed bench for dds_note_sequencer with TICK_DIV=4, DEPTH=16, ARTIC=1.
module tb_dds_note_sequencer;

    logic       clk = 1'b0;
    logic       rst, wr_en, start, stop, loop_i;
    logic [3:0] wr_addr, last;
    logic [7:0] wr_note, note;
    logic [7:0] wr_dur;
    logic       gate, busy, done;
    logic [3:0] step;

    int checks   = 0;
    int failures = 0;

    dds_note_sequencer #(
        .DEPTH(16), .AW(4), .DUR_W(8), .TICK_DIV(4), .ARTIC(1)
    ) dut (
        .CLK(clk), .RESET(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr),
        .WR_NOTE(wr_note), .WR_DUR(wr_dur), .START(start), .STOP(stop),
        .LOOP(loop_i), .LAST(last), .NOTE(note), .GATE(gate), .STEP(step),
        .BUSY(busy), .DONE(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] n, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_note = n; wr_dur = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Pulse START; on return the bench is in cycle 1 (FETCH of step 0)
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) tick();
        checks++;
        if ({note, gate, step, busy, done} !== {8'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got note=%0d gate=%b step=%0d busy=%b done=%b exp 0", note, gate, step, busy, done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({busy, gate, note, step} !== {1'b0, 1'b0, 8'd0, 4'd0}) begin
            failures++;
            $display("FAIL reset_start got busy=%b gate=%b note=%0d step=%0d exp idle", busy, gate, note, step);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [14:0] exp;
        wr(4'd0, 8'd69, 8'd2);
        wr(4'd1, 8'd72, 8'd1);
        last = 4'd1; loop_i = 1'b0;
        do_start();
        checks++;
        if ({busy, step} !== {1'b1, 4'd0}) begin
            failures++;
            $display("FAIL basic_fetch got busy=%b step=%0d exp busy=1 step=0", busy, step);
        end
        for (int c = 2; c <= 16; c++) begin
            tick();
            exp = {(c <= 10) ? 8'd69 : 8'd72,
                   1'((c <= 5) || (c >= 11 && c <= 14)),
                   (c <= 9) ? 4'd0 : 4'd1,
                   1'(c <= 14),
                   1'(c == 15)};
            checks++;
            if ({note, gate, step, busy, done} !== exp) begin
                failures++;
                $display("FAIL basic c=%0d got {note,gate,step,busy,done}=%h exp %h", c, {note, gate, step, busy, done}, exp);
            end
        end
    endtask

    task automatic test_rest_zero();
        logic [14:0] exp;
        wr(4'd0, 8'd0, 8'd3);
        wr(4'd1, 8'd60, 8'd0);
        last = 4'd1; loop_i = 1'b0;
        do_start();
        checks++;
        if (gate !== 1'b0) begin
            failures++;
            $display("FAIL rest_fetch_gate got %b exp 0", gate);
        end
        for (int c = 2; c <= 20; c++) begin
            tick();
            exp = {(c <= 14) ? 8'd0 : 8'd60,
                   1'(c >= 15 && c <= 18),
                   (c <= 13) ? 4'd0 : 4'd1,
                   1'(c <= 18),
                   1'(c == 19)};
            checks++;
            if ({note, gate, step, busy, done} !== exp) begin
                failures++;
                $display("FAIL rest_zero c=%0d got {note,gate,step,busy,done}=%h exp %h", c, {note, gate, step, busy, done}, exp);
            end
        end
    endtask

    task automatic test_loop_wrap();
        logic saw_bad;
        saw_bad = 1'b0;
        for (int i = 0; i < 16; i++) wr(4'(i), 8'(10 + i), 8'd1);
        last = 4'd15; loop_i = 1'b1;
        do_start();
        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < 5; j++) begin
                tick();
                if (done !== 1'b0 || busy !== 1'b1) saw_bad = 1'b1;
                if (j == 0) begin
                    checks++;
                    if ({step, note, gate} !== {4'(k % 16), 8'(10 + (k % 16)), 1'b1}) begin
                        failures++;
                        $display("FAIL loop_step k=%0d got step=%0d note=%0d gate=%b exp step=%0d note=%0d gate=1",
                                 k, step, note, gate, k % 16, 10 + (k % 16));
                    end
                end
            end
        end
        checks++;
        if (saw_bad !== 1'b0) begin
            failures++;
            $display("FAIL loop_busy_done got glitch=%b exp 0", saw_bad);
        end
        do_stop();
        checks++;
        if ({busy, gate, done} !== 3'b000) begin
            failures++;
            $display("FAIL loop_stop got busy=%b gate=%b done=%b exp 000", busy, gate, done);
        end
    endtask

    task automatic test_stop();
        wr(4'd0, 8'd40, 8'd1);
        wr(4'd1, 8'd45, 8'd3);
        last = 4'd1; loop_i = 1'b0;
        do_start();
        repeat (11) tick();
        // now in cycle 12: step 1, second tick
        checks++;
        if ({step, note, gate, busy} !== {4'd1, 8'd45, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL stop_pre got step=%0d note=%0d gate=%b busy=%b exp 1/45/1/1", step, note, gate, busy);
        end
        do_stop();
        checks++;
        if ({busy, gate, done, note, step} !== {1'b0, 1'b0, 1'b0, 8'd45, 4'd1}) begin
            failures++;
            $display("FAIL stop_mid got busy=%b gate=%b done=%b note=%0d step=%0d exp 0/0/0/45/1", busy, gate, done, note, step);
        end
        repeat (6) tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL stop_stays_idle got busy=%b done=%b exp 00", busy, done);
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        checks++;
        if ({busy, step} !== {1'b0, 4'd1}) begin
            failures++;
            $display("FAIL start_stop_idle got busy=%b step=%0d exp busy=0 step=1", busy, step);
        end
        do_start();
        checks++;
        if ({busy, step} !== {1'b1, 4'd0}) begin
            failures++;
            $display("FAIL restart_fetch got busy=%b step=%0d exp 1/0", busy, step);
        end
        tick();
        checks++;
        if ({note, gate} !== {8'd40, 1'b1}) begin
            failures++;
            $display("FAIL restart_play got note=%0d gate=%b exp 40/1", note, gate);
        end
        do_stop();
    endtask

    task automatic test_live_write();
        wr(4'd0, 8'd30, 8'd2);
        wr(4'd1, 8'd31, 8'd1);
        last = 4'd1; loop_i = 1'b1;
        do_start();
        tick();
        // cycle 2: write mem0 during its own playback
        wr(4'd0, 8'd50, 8'd1);
        // cycle 3
        checks++;
        if (note !== 8'd30) begin
            failures++;
            $display("FAIL live_note_held got %0d exp 30", note);
        end
        repeat (8) tick();
        // cycle 11: step 1 playing; pulse START while busy
        checks++;
        if ({step, note} !== {4'd1, 8'd31}) begin
            failures++;
            $display("FAIL live_step1 got step=%0d note=%0d exp 1/31", step, note);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        // cycle 12
        checks++;
        if ({step, note, busy} !== {4'd1, 8'd31, 1'b1}) begin
            failures++;
            $display("FAIL busy_start_ignored got step=%0d note=%0d busy=%b exp 1/31/1", step, note, busy);
        end
        repeat (4) tick();
        // cycle 16: second pass, step 0 with rewritten entry
        checks++;
        if ({step, note, gate} !== {4'd0, 8'd50, 1'b1}) begin
            failures++;
            $display("FAIL live_new_note got step=%0d note=%0d gate=%b exp 0/50/1", step, note, gate);
        end
        repeat (4) tick();
        // cycle 20: new duration of 1 tick already elapsed
        checks++;
        if (step !== 4'd1) begin
            failures++;
            $display("FAIL live_new_dur got step=%0d exp 1", step);
        end
        tick();
        checks++;
        if (note !== 8'd31) begin
            failures++;
            $display("FAIL live_step1_again got note=%0d exp 31", note);
        end
        do_stop();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0; loop_i = 1'b0;
        wr_addr = '0; wr_note = '0; wr_dur = '0; last = '0;
        test_reset();
        test_basic();
        test_rest_zero();
        test_loop_wrap();
        test_stop();
        test_live_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
